// File: rtl/spi_master_scheduler_if.sv
// Requester-side bus of spi_master_scheduler: per-requester requests and transmit words in,
// ownership, completion and the received word out.
interface spi_master_scheduler_if #(
  parameter int N = 4,
  parameter int M = 15
);
  // Handshake: req[i] is a level raised by requester i and held until done[i]; grant[i] is high
  // for the whole owned transfer; done[i] is a one-clk pulse with rx_data valid (or err on abort).
  logic [N-1:0]   req;
  logic [N*M-1:0] tx_data;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic [M-1:0]   rx_data;
  logic           busy;
  logic           err;

  modport master (output req, tx_data, input grant, done, rx_data, busy, err);
  modport slave  (input req, tx_data, output grant, done, rx_data, busy, err);
endinterface

// File: rtl/spi_master_scheduler.sv
// Shares one SPI master core between N requesters: round-robin grant, chip selects, ce/st
// generation and receive capture. Define SPI_SCHED_TIMEOUT_EN to add the transfer watchdog.
module spi_master_scheduler #(
  parameter int N   = 4,
  parameter int M   = 15,
  parameter int DIV = 4,
  parameter int GAP = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_master_scheduler_if.slave app,
  output logic                  spi_ce,
  output logic                  spi_st,
  output logic [M-1:0]          spi_tx,
  input  logic                  spi_load,
  input  logic [M-1:0]          spi_rx,
  output logic [N-1:0]          cs_n,
  output logic [2:0]            dbg_state
);
  localparam int PW = $clog2(N);
  localparam int DW = $clog2(DIV);
  localparam int TW = $clog2(GAP + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    START   = 3'd2,
    SHIFT   = 3'd3,
    CAPTURE = 3'd4,
    GUARD   = 3'd5
  } state_t;

  state_t         state, state_nx;
  logic [DW-1:0]  div_cnt;
  logic           div_wrap, ce_rise;
  logic           load_m, load_s;
  logic [1:0]     sync_fill;
  logic           sync_ok;
  logic [TW-1:0]  tick_cnt;
  logic           low_seen;
  logic [PW-1:0]  ptr, pick, idx;
  logic           pick_vld;
  logic [N-1:0]   grant_r, done_r;
  logic [M-1:0]   rx_r;
  logic           err_r;
  logic           wd_expire;
  logic [M-1:0]   tx_word [N];

  // Free-running bit-rate divider; ce_rise marks the clk on which spi_ce goes high.
  assign div_wrap = (div_cnt == DW'(DIV - 1));
  assign ce_rise  = div_wrap & ~spi_ce;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      spi_ce  <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      spi_ce  <= ~spi_ce;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // The sync flops reset to 1, so IDLE also waits until the pipeline has refilled from the
  // real LOAD; otherwise a core still shifting from before reset would look idle for 2 clks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_m    <= 1'b1;
      load_s    <= 1'b1;
      sync_fill <= 2'b00;
    end else begin
      load_m    <= spi_load;
      load_s    <= load_m;
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end
  assign sync_ok = sync_fill[1];

  for (genvar g = 0; g < N; g++) begin : g_tx_word
    assign tx_word[g] = app.tx_data[g*M +: M];
  end

  // Round robin: first active request searching upward from the last owner.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int k = 1; k <= N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!pick_vld && app.req[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

`ifdef SPI_SCHED_TIMEOUT_EN
  localparam int WDW = $clog2(2*M + 4);
  logic [WDW-1:0] wd_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                wd_cnt <= '0;
    else if (state != START && state != SHIFT) wd_cnt <= '0;
    else if (ce_rise)                       wd_cnt <= wd_cnt + 1'b1;
  end

  assign wd_expire = (state == START || state == SHIFT) && ce_rise &&
                     (wd_cnt == WDW'(2*M + 3));
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // SETUP and GUARD skip the first (partial) ce period so their waits are whole periods.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (load_s && sync_ok && pick_vld)      state_nx = SETUP;
      SETUP:   if (ce_rise && tick_cnt == TW'(1))      state_nx = START;
      START:   if (ce_rise)                            state_nx = SHIFT;
      SHIFT:   if (low_seen && load_s)                 state_nx = CAPTURE;
      CAPTURE:                                         state_nx = GUARD;
      GUARD:   if (ce_rise && tick_cnt == TW'(GAP))    state_nx = IDLE;
      default:                                         state_nx = IDLE;
    endcase
    if (wd_expire) state_nx = GUARD;
  end

  always_comb begin
    app.busy  = (state != IDLE);
    spi_st    = (state == START);
    cs_n      = ~grant_r;
    dbg_state = 3'(state);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      low_seen <= 1'b0;
    end else if (state_nx != state) begin
      tick_cnt <= '0;
      low_seen <= 1'b0;
    end else begin
      if (ce_rise) tick_cnt <= tick_cnt + 1'b1;
      if (!load_s) low_seen <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_r <= '0;
      done_r  <= '0;
      rx_r    <= '0;
      err_r   <= 1'b0;
      spi_tx  <= '0;
      ptr     <= PW'(N - 1);
    end else begin
      done_r <= '0;
      err_r  <= 1'b0;
      if (state == IDLE && state_nx == SETUP) begin
        grant_r       <= '0;
        grant_r[pick] <= 1'b1;
        spi_tx        <= tx_word[pick];
        ptr           <= pick;
      end
      if (state == SHIFT && state_nx == CAPTURE) begin
        rx_r   <= spi_rx;
        done_r <= grant_r;
      end
      if (state == CAPTURE) grant_r <= '0;
      if (wd_expire) begin
        err_r   <= 1'b1;
        done_r  <= grant_r;
        grant_r <= '0;
      end
    end
  end

  assign app.grant   = grant_r;
  assign app.done    = done_r;
  assign app.rx_data = rx_r;
  assign app.err     = err_r;
endmodule
